// File: rtl/lzs_pkg.sv
// Shared LZS decoder definitions: default stream geometry and the fetch-state type.
package lzs_pkg;

   localparam int unsigned LZS_IN_W     = 64;
   localparam int unsigned LZS_MAX_TAKE = 13;

   typedef enum logic {
      F_IDLE = 1'b0,
      F_WAIT = 1'b1
   } lzs_fetch_e;

endpackage

// File: rtl/lzs_bit_shifter.sv
// Accumulator update: left shift by the discarded bit count, then OR the fetched
// word in just below the surviving bits.
module lzs_bit_shifter #(
   parameter int unsigned IN_W = 64,
   parameter int unsigned CW   = 8
) (
   input  logic [2*IN_W-1:0] acc,
   input  logic [CW-1:0]     shamt,
   input  logic              load,
   input  logic [IN_W-1:0]   word,
   input  logic [CW-1:0]     pos,
   output logic [2*IN_W-1:0] acc_next
);

   localparam int unsigned AW = 2 * IN_W;

   logic [AW-1:0] shifted;
   logic [AW-1:0] placed;

   always_comb begin
      shifted  = acc << shamt;
      placed   = '0;
      if (load) begin
         placed = {word, {IN_W{1'b0}}} >> pos;
      end
      acc_next = shifted | placed;
   end

endmodule

// File: rtl/lzs_bit_unpack.sv
// LZS input stage: pops source words into an MSB-first bit accumulator and hands
// up to MAX_TAKE bits per acknowledge to the token parser.
// Optional byte-alignment skipping is enabled by LZS_UNPACK_BYTE_ALIGN_EN.
module lzs_bit_unpack
   import lzs_pkg::*;
#(
   parameter int unsigned IN_W     = LZS_IN_W,
   parameter int unsigned MAX_TAKE = LZS_MAX_TAKE,
   parameter int unsigned WW       = $clog2(MAX_TAKE + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ce,
   input  logic                src_empty,
   input  logic [IN_W-1:0]     fi,
   input  logic                m_last,
   input  logic                fo_full,
   output logic                m_src_getn,
   output logic [MAX_TAKE-1:0] stream_data,
   output logic                stream_valid,
   output logic                stream_done,
   input  logic [WW-1:0]       stream_width,
   input  logic                stream_ack
`ifdef LZS_UNPACK_BYTE_ALIGN_EN
   ,
   input  logic                stream_align
`endif
);

   localparam int unsigned AW = 2 * IN_W;
   localparam int unsigned CW = $clog2(AW + 1);

   lzs_fetch_e          state_q, state_d;
   logic [AW-1:0]       acc_q, acc_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                last_q, last_d;
   logic                done_q, done_d;
   logic                valid_q, valid_d;
   logic [MAX_TAKE-1:0] data_q, data_d;

   logic                fetch_c;
   logic                load;
   logic [CW-1:0]       req;
   logic [CW-1:0]       take;
   logic [CW-1:0]       total;
   logic [CW-1:0]       pos;

`ifdef LZS_UNPACK_BYTE_ALIGN_EN
   logic [2:0]          bitpos_q, bitpos_d;
   logic [2:0]          bp_mid;
   logic [2:0]          pad3;
   logic [CW-1:0]       room;
   logic [CW-1:0]       pad;
`endif

   // Fetch FSM, consume amount and next-state of the accumulator.
   always_comb begin
      state_d = state_q;
      fetch_c = 1'b0;
      load    = 1'b0;
      req     = CW'(stream_width);
      take    = '0;
      total   = '0;
      last_d  = last_q;
      done_d  = done_q;
`ifdef LZS_UNPACK_BYTE_ALIGN_EN
      bitpos_d = bitpos_q;
      bp_mid   = '0;
      pad3     = '0;
      room     = '0;
      pad      = '0;
`endif

      if (req > CW'(MAX_TAKE)) begin
         req = CW'(MAX_TAKE);
      end

      if (ce) begin
         unique case (state_q)
            F_IDLE: begin
               if (!src_empty && !fo_full && !last_q && !done_q && (cnt_q <= CW'(IN_W))) begin
                  fetch_c = 1'b1;
                  state_d = F_WAIT;
               end
            end
            F_WAIT: begin
               load    = 1'b1;
               state_d = F_IDLE;
            end
         endcase

         // valid_q already folds in done, so acks after completion fall through.
         if (stream_ack && valid_q) begin
            take  = (req > cnt_q) ? cnt_q : req;
            total = take;
`ifdef LZS_UNPACK_BYTE_ALIGN_EN
            if (stream_align) begin
               bp_mid = bitpos_q + take[2:0];
               pad3   = 3'd0 - bp_mid;
               room   = cnt_q - take;
               pad    = (CW'(pad3) > room) ? room : CW'(pad3);
               total  = take + pad;
            end
            bitpos_d = bitpos_q + total[2:0];
`endif
         end

         last_d = last_q | (load & m_last);
         done_d = done_q | (last_q && (cnt_q == '0) && (state_q == F_IDLE));
      end

      pos     = cnt_q - total;
      cnt_d   = pos + (load ? CW'(IN_W) : CW'(0));
      valid_d = !done_d && ((cnt_d >= CW'(MAX_TAKE)) || (last_d && (cnt_d != '0)));
      data_d  = acc_d[AW-1 -: MAX_TAKE];
   end

   lzs_bit_shifter #(
      .IN_W (IN_W),
      .CW   (CW)
   ) u_shift (
      .acc      (acc_q),
      .shamt    (total),
      .load     (load),
      .word     (fi),
      .pos      (pos),
      .acc_next (acc_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= F_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

`ifdef LZS_UNPACK_BYTE_ALIGN_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bitpos_q <= '0;
      end else begin
         bitpos_q <= bitpos_d;
      end
   end
`endif

   // The pop strobe must fall in the deciding cycle; reset forces it inactive.
   assign m_src_getn   = ~(fetch_c & rst);
   assign stream_data  = data_q;
   assign stream_valid = valid_q;
   assign stream_done  = done_q;

endmodule

// File: tb/tb_lzs_bit_unpack.sv
// Directed bench for lzs_bit_unpack: vector table for the basic stream plus
// hand-written sequences for backpressure, load/consume overlap, reset and ce.
module tb_lzs_bit_unpack;
   import lzs_pkg::*;

   localparam int unsigned IN_W     = 64;
   localparam int unsigned MAX_TAKE = 13;
   localparam int unsigned WW       = 4;
   localparam logic [63:0] PAT_A5   = 64'hA5A5_A5A5_A5A5_A5A5;
   localparam logic [63:0] PAT_FF   = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct {
      logic [WW-1:0]       width;
      logic [MAX_TAKE-1:0] data;
      logic                valid;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic ce;
   logic src_empty;
   logic [IN_W-1:0] fi;
   logic m_last;
   logic fo_full;
   logic m_src_getn;
   logic [MAX_TAKE-1:0] stream_data;
   logic stream_valid;
   logic stream_done;
   logic [WW-1:0] stream_width;
   logic stream_ack;
`ifdef LZS_UNPACK_BYTE_ALIGN_EN
   logic stream_align;
`endif

   logic [63:0] words [2];
   logic        lasts [2];
   int          widx;
   int          nwords;
   logic        force_empty;
   int          pass_cnt;
   int          total_cnt;
   vec_t        vecs [10];

   always #5 clk = ~clk;

   lzs_bit_unpack dut (
      .clk          (clk),
      .rst          (rst),
      .ce           (ce),
      .src_empty    (src_empty),
      .fi           (fi),
      .m_last       (m_last),
      .fo_full      (fo_full),
      .m_src_getn   (m_src_getn),
      .stream_data  (stream_data),
      .stream_valid (stream_valid),
      .stream_done  (stream_done),
      .stream_width (stream_width),
      .stream_ack   (stream_ack)
`ifdef LZS_UNPACK_BYTE_ALIGN_EN
      ,
      .stream_align (stream_align)
`endif
   );

   always @(posedge clk) begin
      if (rst) begin
         assert (dut.cnt_q <= 8'(2 * IN_W))
            else $error("FAIL cnt_bound: cnt=%0d exceeds %0d", dut.cnt_q, 2 * IN_W);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: the bench FIFO pops on a sampled low getn and presents the word after the edge.
   task automatic tick();
      logic pop;
      #1;
      pop = !m_src_getn;
      @(posedge clk);
      #1;
      if (pop && (widx < nwords)) begin
         fi     = words[widx];
         m_last = lasts[widx];
         widx++;
      end
      src_empty = force_empty || (widx >= nwords);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst          = 1'b0;
      ce           = 1'b1;
      fo_full      = 1'b0;
      stream_ack   = 1'b0;
      stream_width = '0;
      force_empty  = 1'b0;
`ifdef LZS_UNPACK_BYTE_ALIGN_EN
      stream_align = 1'b0;
`endif
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic load_src(input logic [63:0] a, input logic la,
                           input logic [63:0] b, input logic lb, input int n);
      words[0]  = a;
      lasts[0]  = la;
      words[1]  = b;
      lasts[1]  = lb;
      widx      = 0;
      nwords    = n;
      src_empty = (n == 0);
   endtask

   task automatic ack(input logic [WW-1:0] w);
      stream_width = w;
      stream_ack   = 1'b1;
      tick();
      stream_ack   = 1'b0;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      rst       = 1'b0;
      ce        = 1'b1;
      src_empty = 1'b0;
      fi        = '0;
      m_last    = 1'b0;
      fo_full   = 1'b0;
      stream_ack   = 1'b0;
      stream_width = '0;
      force_empty  = 1'b0;
      widx      = 0;
      nwords    = 0;
`ifdef LZS_UNPACK_BYTE_ALIGN_EN
      stream_align = 1'b0;
`endif

      vecs[0] = '{4'd13, 13'h14B4, 1'b1};
      vecs[1] = '{4'd13, 13'h1696, 1'b1};
      vecs[2] = '{4'd13, 13'h12D2, 1'b1};
      vecs[3] = '{4'd13, 13'h1A5A, 1'b1};
      vecs[4] = '{4'd13, 13'h0B4B, 1'b1};
      vecs[5] = '{4'd13, 13'h0969, 1'b1};
      vecs[6] = '{4'd13, 13'h0D2D, 1'b1};
      vecs[7] = '{4'd13, 13'h05A5, 1'b1};
      vecs[8] = '{4'd13, 13'h14B4, 1'b1};
      vecs[9] = '{4'd13, 13'h1694, 1'b1};

      // Reset values, held with a non-empty source.
      repeat (2) @(negedge clk);
      #1;
      chk("rst_getn",  32'(m_src_getn),   32'd1);
      chk("rst_valid", 32'(stream_valid), 32'd0);
      chk("rst_done",  32'(stream_done),  32'd0);
      chk("rst_data",  32'(stream_data),  32'd0);
      chk("rst_cnt",   32'(dut.cnt_q),    32'd0);
`ifdef LZS_UNPACK_BYTE_ALIGN_EN
      chk("rst_bitpos", 32'(dut.bitpos_q), 32'd0);
`endif

      // Basic stream: two A5 words, second marked last, 13-bit acks to completion.
      do_reset();
      load_src(PAT_A5, 1'b0, PAT_A5, 1'b1, 2);
      repeat (5) tick();
      chk("basic_cnt", 32'(dut.cnt_q), 32'd128);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("basic_data[%0d]", i),  32'(stream_data),  32'(vecs[i].data));
         chk($sformatf("basic_valid[%0d]", i), 32'(stream_valid), 32'(vecs[i].valid));
         ack(vecs[i].width);
      end
      chk("basic_empty_valid", 32'(stream_valid), 32'd0);
      chk("basic_empty_data",  32'(stream_data),  32'd0);
      tick();
      chk("basic_done",        32'(stream_done),  32'd1);
      chk("basic_done_valid",  32'(stream_valid), 32'd0);
      ack(4'd5);
      chk("basic_post_ack_done", 32'(stream_done), 32'd1);
      chk("basic_post_ack_cnt",  32'(dut.cnt_q),   32'd0);
      #1;
      chk("basic_post_getn",     32'(m_src_getn),  32'd1);

      // Backpressure: fo_full blocks the first fetch, release gives pulse then data.
      do_reset();
      load_src(64'h0123_4567_89AB_CDEF, 1'b1, 64'h0, 1'b0, 1);
      fo_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp_getn_held[%0d]", i), 32'(m_src_getn),   32'd1);
         chk($sformatf("bp_valid[%0d]", i),     32'(stream_valid), 32'd0);
         tick();
      end
      fo_full = 1'b0;
      #1;
      chk("bp_getn_pulse", 32'(m_src_getn), 32'd0);
      tick();
      #1;
      chk("bp_getn_end",   32'(m_src_getn),   32'd1);
      chk("bp_valid_n1",   32'(stream_valid), 32'd0);
      tick();
      chk("bp_valid_n2",   32'(stream_valid), 32'd1);
      chk("bp_data_n2",    32'(stream_data),  32'h0024);

      // Consume in the same cycle as a load at cnt=64.
      do_reset();
      load_src(PAT_A5, 1'b0, PAT_FF, 1'b0, 2);
      tick();
      tick();
      chk("sim_cnt_pre",  32'(dut.cnt_q),   32'd64);
      chk("sim_data_pre", 32'(stream_data), 32'h14B4);
      tick();
      chk("sim_state",    32'(dut.state_q), 32'(F_WAIT));
      ack(4'd13);
      chk("sim_cnt",      32'(dut.cnt_q),   32'd115);
      chk("sim_data",     32'(stream_data), 32'h1696);
      ack(4'd13);
      ack(4'd13);
      ack(4'd13);
      ack(4'd8);
      chk("sim_join_data", 32'(stream_data), 32'h0BFF);
      chk("sim_join_cnt",  32'(dut.cnt_q),   32'd68);

      // Reset while the second fetch is outstanding; the popped word is dropped.
      do_reset();
      load_src(PAT_A5, 1'b0, PAT_A5, 1'b1, 2);
      repeat (3) tick();
      chk("rw_valid_pre", 32'(stream_valid), 32'd1);
      rst         = 1'b0;
      force_empty = 1'b1;
      src_empty   = 1'b1;
      #1;
      chk("rw_getn",  32'(m_src_getn),   32'd1);
      chk("rw_valid", 32'(stream_valid), 32'd0);
      chk("rw_data",  32'(stream_data),  32'd0);
      chk("rw_done",  32'(stream_done),  32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) tick();
      chk("rw_cnt_after",   32'(dut.cnt_q),   32'd0);
      chk("rw_valid_after", 32'(stream_valid), 32'd0);

      // ce low freezes a stream that would otherwise fetch and consume.
      do_reset();
      load_src(PAT_A5, 1'b0, PAT_A5, 1'b1, 2);
      tick();
      tick();
      ce           = 1'b0;
      stream_ack   = 1'b1;
      stream_width = 4'd13;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("ce_getn[%0d]", i), 32'(m_src_getn), 32'd1);
         tick();
      end
      chk("ce_cnt_hold",   32'(dut.cnt_q),   32'd64);
      chk("ce_data_hold",  32'(stream_data), 32'h14B4);
      chk("ce_valid_hold", 32'(stream_valid), 32'd1);
      ce         = 1'b1;
      stream_ack = 1'b0;
      #1;
      chk("ce_resume_getn", 32'(m_src_getn), 32'd0);
      tick();
      tick();
      chk("ce_resume_cnt",  32'(dut.cnt_q),   32'd128);
      chk("ce_resume_data", 32'(stream_data), 32'h14B4);

`ifdef LZS_UNPACK_BYTE_ALIGN_EN
      // Aligned acks round the consumed total up to the next byte boundary.
      do_reset();
      load_src(PAT_A5, 1'b0, PAT_A5, 1'b1, 2);
      repeat (5) tick();
      stream_align = 1'b1;
      ack(4'd9);
      stream_align = 1'b0;
      chk("al_cnt",    32'(dut.cnt_q),    32'd112);
      chk("al_bitpos", 32'(dut.bitpos_q), 32'd0);
      chk("al_data",   32'(stream_data),  32'h14B4);
      ack(4'd3);
      chk("al_bitpos3", 32'(dut.bitpos_q), 32'd3);
      stream_align = 1'b1;
      ack(4'd2);
      stream_align = 1'b0;
      chk("al_cnt2",    32'(dut.cnt_q),    32'd104);
      chk("al_bitpos2", 32'(dut.bitpos_q), 32'd0);
      chk("al_data2",   32'(stream_data),  32'h14B4);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
